fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   Instruction fetch stage; sits directly upstream of the instruction memory.
//   Owns the program counter, drives the imem word address, and latches the
//   returned instruction into the IF/ID register for decode.
//   Handles stall, branch/jump redirect with wrong-path squash, and halt.
// PARAMETERS
//   IWIDTH   16  instruction width; must match imem rd.
//   AWIDTH    6  PC / imem address width (64-instruction .text).
//   CWIDTH   16  width of the fetched-instruction counter.
// PORTS
//   clk          in   1       rising-edge clock
//   reset        in   1       synchronous, active-high reset
//   stall        in   1       decode backpressure; hold PC and IR
//   redirect     in   1       taken branch/jump; load redirect_pc
//   redirect_pc  in   AWIDTH  redirect target (instruction index)
//   imem_a       out  AWIDTH  imem word address (= pc, combinational)
//   imem_rd      in   IWIDTH  imem read data (combinational from imem_a)
//   ir           out  IWIDTH  IF/ID instruction register
//   ir_pc        out  AWIDTH  PC of the instruction held in ir
//   ir_valid     out  1       ir holds a valid instruction
//   halted       out  1       fetch stopped (HALTED state)
//   fetch_count  out  CWIDTH  count of instructions loaded with ir_valid=1
// BEHAVIOUR
//   - Reset (priority over all inputs): pc=0, ir=0, ir_pc=0, ir_valid=0,
//     halted=0, fetch_count=0, state=RUN. A mid-operation reset discards
//     everything in one edge.
//   - imem_a = pc every cycle; the imem read is combinational, so a word is
//     fetched each cycle. Latency: address-to-IR is 1 edge.
//   - FSM states: RUN, HALTED. halted = (state==HALTED), a registered output.
//   - RUN, per edge, priority redirect > stall > normal:
//       redirect: pc<=redirect_pc; ir_valid<=0 (squash the word fetched this
//         cycle); ir and ir_pc hold; count holds. Applies even under stall.
//       stall: pc, ir, ir_pc, ir_valid, and count all hold.
//       normal: ir<=imem_rd; ir_pc<=pc; ir_valid<=1; pc<=pc+1;
//         count<=count+1.
//   - After a redirect, the target instruction appears in ir 2 edges later.
//   - pc arithmetic is modulo 2^AWIDTH: pc=63 increments to 0, with no flag
//     and no stall.
//   - fetch_count saturates at all-ones and does not wrap.
//   - HALTED: pc, ir, ir_pc, and count hold; ir_valid=0; stall is ignored.
//     A redirect returns the FSM to RUN with pc<=redirect_pc, ir_valid=0.
//   - Without FETCH_HALT_ON_ZERO_EN, HALTED is unreachable.
// CONFIGURATION
//   FETCH_HALT_ON_ZERO_EN defined:
//     - In RUN, with no redirect and no stall, imem_rd==0 (the imem clears
//       unused lines to zero) is treated as a halt marker.
//     - The next state is HALTED. pc holds at the marker address;
//       ir_valid<=0; ir is not loaded; count is not incremented.
//   FETCH_HALT_ON_ZERO_EN undefined:
//     - A zero word is an ordinary instruction, loaded and counted.
//     - halted is tied to 0.
// TESTING
//   1. Reset, imem words 0..3 = 16'h1111,2222,3333,4444, no stall.
//      -> After edges 1..4: ir = 1111,2222,3333,4444; ir_pc = 0..3;
//         ir_valid=1 from edge 1; fetch_count=4.
//   2. stall=1 for 3 cycles with ir=2222.
//      -> ir, ir_pc=1, pc=2, and count are unchanged.
//      -> Release stall: the next edge loads 3333.
//   3. redirect=1, redirect_pc=6'd40, asserted together with stall=1.
//      -> Next edge: pc=40, ir_valid=0.
//      -> Following edge: ir=RAM[40], ir_pc=40.
//   4. pc=63, no stall.
//      -> ir_pc=63 loaded; pc wraps to 0; next ir = RAM[0].
//   5. FETCH_HALT_ON_ZERO_EN, RAM[5]=0.
//      -> After the edge fetching address 5: halted=1, ir_valid=0, pc=5.
//      -> A redirect to 0 clears halted.
//      -> Without the macro: ir=0 with ir_valid=1 and halted=0.
//   6. Assert reset mid-stream.
//      -> Next edge: pc=0, ir_valid=0, fetch_count=0, halted=0.

Source files
------------

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: pc, imem address, IF/ID register
// Optional FETCH_HALT_ON_ZERO_EN: a zero imem word in RUN halts fetch.
module fetch_stage #(
    parameter int IWIDTH = 16,
    parameter int AWIDTH = 6,
    parameter int CWIDTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [AWIDTH-1:0] redirect_pc,
    output logic [AWIDTH-1:0] imem_a,
    input  logic [IWIDTH-1:0] imem_rd,
    output logic [IWIDTH-1:0] ir,
    output logic [AWIDTH-1:0] ir_pc,
    output logic              ir_valid,
    output logic              halted,
    output logic [CWIDTH-1:0] fetch_count
);

    typedef enum logic {RUN, HALTED} state_t;

    state_t            state, state_next;
    logic [AWIDTH-1:0] pc, pc_next;
    logic [IWIDTH-1:0] ir_next;
    logic [AWIDTH-1:0] ir_pc_next;
    logic              ir_valid_next;
    logic [CWIDTH-1:0] count_next;
    logic              halt_marker;

    assign imem_a = pc;

`ifdef FETCH_HALT_ON_ZERO_EN
    assign halt_marker = (imem_rd == '0);
    assign halted      = (state == HALTED);
`else
    assign halt_marker = 1'b0;
    assign halted      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            pc          <= '0;
            ir          <= '0;
            ir_pc       <= '0;
            ir_valid    <= 1'b0;
            fetch_count <= '0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            ir          <= ir_next;
            ir_pc       <= ir_pc_next;
            ir_valid    <= ir_valid_next;
            fetch_count <= count_next;
        end
    end

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        ir_next       = ir;
        ir_pc_next    = ir_pc;
        ir_valid_next = ir_valid;
        count_next    = fetch_count;
        case (state)
            RUN: begin
                if (redirect) begin
                    // The word fetched this cycle is wrong-path; squash it.
                    pc_next       = redirect_pc;
                    ir_valid_next = 1'b0;
                end else if (stall) begin
                    ir_valid_next = ir_valid;
                end else if (halt_marker) begin
                    state_next    = HALTED;
                    ir_valid_next = 1'b0;
                end else begin
                    ir_next       = imem_rd;
                    ir_pc_next    = pc;
                    ir_valid_next = 1'b1;
                    pc_next       = pc + AWIDTH'(1);
                    if (fetch_count != {CWIDTH{1'b1}})
                        count_next = fetch_count + CWIDTH'(1);
                end
            end
            HALTED: begin
                ir_valid_next = 1'b0;
                if (redirect) begin
                    state_next = RUN;
                    pc_next    = redirect_pc;
                end
            end
            default: state_next = RUN;
        endcase
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage against a reference model
module tb_fetch_stage;
    localparam int IW = 16;
    localparam int AW = 6;
    localparam int CW = 4;
`ifdef FETCH_HALT_ON_ZERO_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, stall, redirect;
    logic [AW-1:0] redirect_pc;
    logic [AW-1:0] imem_a;
    logic [IW-1:0] imem_rd;
    logic [IW-1:0] ir;
    logic [AW-1:0] ir_pc;
    logic          ir_valid, halted;
    logic [CW-1:0] fetch_count;

    logic [IW-1:0] mem [64];

    int tests = 0;
    int fails = 0;

    // reference model state
    int            m_pc, m_ir_pc, m_count;
    logic [IW-1:0] m_ir;
    logic          m_valid, m_halted;

    always #5 clk = ~clk;

    assign imem_rd = mem[imem_a];

    fetch_stage #(.IWIDTH(IW), .AWIDTH(AW), .CWIDTH(CW)) dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_a(imem_a), .imem_rd(imem_rd),
        .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .halted(halted),
        .fetch_count(fetch_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_imem_a"},   32'(imem_a),      32'(m_pc));
        chk({tag, "_ir"},       32'(ir),          32'(m_ir));
        chk({tag, "_ir_pc"},    32'(ir_pc),       32'(m_ir_pc));
        chk({tag, "_ir_valid"}, 32'(ir_valid),    32'(m_valid));
        chk({tag, "_halted"},   32'(halted),      32'(m_halted));
        chk({tag, "_count"},    32'(fetch_count), 32'(m_count));
    endtask

    // One clock: apply inputs, advance the model by the fetch rules, check after the edge.
    task automatic cycle(input logic r, input logic s, input logic rd, input int rpc, input string tag);
        logic [IW-1:0] w;
        reset = r; stall = s; redirect = rd; redirect_pc = AW'(rpc);
        w = mem[m_pc];
        if (r) begin
            m_pc = 0; m_ir = '0; m_ir_pc = 0; m_valid = 0; m_halted = 0; m_count = 0;
        end else if (m_halted) begin
            m_valid = 0;
            if (rd) begin m_halted = 0; m_pc = rpc; end
        end else if (rd) begin
            m_pc = rpc; m_valid = 0;
        end else if (s) begin
            m_valid = m_valid;
        end else if (HALT_EN && w == '0) begin
            m_halted = 1; m_valid = 0;
        end else begin
            m_ir = w; m_ir_pc = m_pc; m_valid = 1;
            m_pc = (m_pc + 1) % 64;
            m_count = (m_count + 1 > 15) ? 15 : m_count + 1;
        end
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        m_pc = 0; m_ir = '0; m_ir_pc = 0; m_valid = 0; m_halted = 0; m_count = 0;
        for (int i = 0; i < 64; i++) mem[i] = IW'($urandom_range(1, 16'hffff));
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;

        cycle(1, 0, 0, 0, "reset");
        chk("reset_valid", 32'(ir_valid), 32'd0);

        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, "t1");
        chk("t1_ir", 32'(ir), 32'h4444);
        chk("t1_ir_pc", 32'(ir_pc), 32'd3);
        chk("t1_count", 32'(fetch_count), 32'd4);

        cycle(1, 0, 0, 0, "t2_reset");
        cycle(0, 0, 0, 0, "t2_a");
        cycle(0, 0, 0, 0, "t2_b");
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, "t2_stall");
        chk("t2_ir", 32'(ir), 32'h2222);
        chk("t2_ir_pc", 32'(ir_pc), 32'd1);
        chk("t2_pc", 32'(imem_a), 32'd2);
        chk("t2_count", 32'(fetch_count), 32'd2);
        cycle(0, 0, 0, 0, "t2_release");
        chk("t2_release_ir", 32'(ir), 32'h3333);

        cycle(0, 1, 1, 40, "t3_redirect");
        chk("t3_pc", 32'(imem_a), 32'd40);
        chk("t3_valid", 32'(ir_valid), 32'd0);
        cycle(0, 0, 0, 0, "t3_target");
        chk("t3_ir", 32'(ir), 32'(mem[40]));
        chk("t3_ir_pc", 32'(ir_pc), 32'd40);

        cycle(0, 0, 1, 63, "t4_redirect");
        cycle(0, 0, 0, 0, "t4_wrap");
        chk("t4_ir_pc", 32'(ir_pc), 32'd63);
        chk("t4_pc", 32'(imem_a), 32'd0);
        cycle(0, 0, 0, 0, "t4_next");
        chk("t4_ir", 32'(ir), 32'h1111);

        mem[5] = '0;
        cycle(0, 0, 1, 5, "t5_redirect");
        cycle(0, 0, 0, 0, "t5_fetch0");
        chk("t5_halted", 32'(halted), 32'(HALT_EN));
        chk("t5_valid", 32'(ir_valid), 32'(!HALT_EN));
        chk("t5_pc", 32'(imem_a), HALT_EN ? 32'd5 : 32'd6);
        if (!HALT_EN) chk("t5_ir", 32'(ir), 32'd0);
        cycle(0, 1, 0, 0, "t5_stall");
        cycle(0, 0, 1, 0, "t5_resume");
        chk("t5_unhalt", 32'(halted), 32'd0);
        mem[5] = 16'h5555;

        for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, "sat");
        chk("sat_count", 32'(fetch_count), 32'd15);

        for (int i = 0; i < 64; i++)
            mem[i] = ($urandom_range(0, 9) == 0) ? '0 : IW'($urandom);
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0, int'($urandom_range(0, 63)), "rand");

        cycle(0, 0, 1, 20, "t6_pre");
        cycle(0, 0, 0, 0, "t6_run");
        cycle(1, 1, 1, 9, "t6_reset");
        chk("t6_pc", 32'(imem_a), 32'd0);
        chk("t6_valid", 32'(ir_valid), 32'd0);
        chk("t6_count", 32'(fetch_count), 32'd0);
        chk("t6_halted", 32'(halted), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
